// File: rtl/fb_write_sched.sv
// Framebuffer write scheduler: unpacks serial bytes into two-plane row words
// and issues them as valid/ready writes, with a whole-buffer fill mode.
module fb_write_sched #(
  parameter int ROWS    = 80,
  parameter int TIMEOUT = 24000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_strobe,
  input  logic        clear_req,
  input  logic [31:0] clear_value,
  output logic [6:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic        frame_done,
  output logic        overflow,
  output logic        busy
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [8:0]        OFF_LAST  = 9'(4 * ROWS - 1);
  localparam logic [6:0]        ROW_LAST  = 7'(ROWS - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]        state_r;
  logic [8:0]        offset_r;
  logic [31:0]       acc_r;
  logic [IDLE_W-1:0] idle_r;
  logic [31:0]       clear_val_r;
  logic [6:0]        wr_addr_r;
  logic [31:0]       wr_data_r;
  logic              wr_valid_r;
  logic              frame_done_r;
  logic              overflow_r;
  logic              busy_r;

  logic              hs_s;
  logic [3:0]        p0_s;
  logic [3:0]        p1_s;
  logic [31:0]       acc_next_s;
  logic              word_done_s;
  logic              can_load_s;
  logic [8:0]        offset_next_s;
  logic              pend_next_s;

  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign wr_valid   = wr_valid_r;
  assign frame_done = frame_done_r;
  assign overflow   = overflow_r;
  assign busy       = busy_r;

  // Byte unpacking, handshake and pending-slot availability
  always_comb begin
    hs_s = wr_valid_r & wr_ready;
    p0_s = {rx_data[6], rx_data[4], rx_data[2], rx_data[0]};
    p1_s = {rx_data[7], rx_data[5], rx_data[3], rx_data[1]};
    acc_next_s = acc_r;
    case (offset_r[1:0])
      2'd0: begin
        acc_next_s[15:12] = p0_s;
        acc_next_s[31:28] = p1_s;
      end
      2'd1: begin
        acc_next_s[11:8]  = p0_s;
        acc_next_s[27:24] = p1_s;
      end
      2'd2: begin
        acc_next_s[7:4]   = p0_s;
        acc_next_s[23:20] = p1_s;
      end
      2'd3: begin
        acc_next_s[3:0]   = p0_s;
        acc_next_s[19:16] = p1_s;
      end
      default: acc_next_s = acc_r;
    endcase
    word_done_s = rx_strobe & (offset_r[1:0] == 2'd3);
    // A slot freed by this cycle's handshake can take a new word immediately
    can_load_s  = ~wr_valid_r | hs_s;
    if (offset_r == OFF_LAST) begin
      offset_next_s = 9'd0;
    end else begin
      offset_next_s = offset_r + 9'd1;
    end
    pend_next_s = (word_done_s & can_load_s) | (wr_valid_r & ~hs_s);
  end

  // Scheduler state, byte accumulation and write-port registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_LOAD;
      offset_r     <= 9'd0;
      acc_r        <= 32'd0;
      idle_r       <= '0;
      clear_val_r  <= 32'd0;
      wr_addr_r    <= 7'd0;
      wr_data_r    <= 32'd0;
      wr_valid_r   <= 1'b0;
      frame_done_r <= 1'b0;
      overflow_r   <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      frame_done_r <= hs_s & (wr_addr_r == ROW_LAST);
      if (hs_s) begin
        wr_valid_r <= 1'b0;
      end
      case (state_r)
        ST_LOAD: begin
          if (rx_strobe) begin
            idle_r   <= '0;
            offset_r <= offset_next_s;
            if (word_done_s) begin
              acc_r <= 32'd0;
              if (can_load_s) begin
                wr_valid_r <= 1'b1;
                wr_addr_r  <= offset_r[8:2];
                wr_data_r  <= acc_next_s;
              end else begin
                overflow_r <= 1'b1;
              end
            end else begin
              acc_r <= acc_next_s;
            end
          end else if (offset_r != 9'd0) begin
            if (idle_r == IDLE_LAST) begin
              offset_r <= 9'd0;
              acc_r    <= 32'd0;
              idle_r   <= '0;
            end else begin
              idle_r <= idle_r + IDLE_ONE;
            end
          end else begin
            idle_r <= '0;
          end
          if (clear_req) begin
            clear_val_r <= clear_value;
            offset_r    <= 9'd0;
            acc_r       <= 32'd0;
            idle_r      <= '0;
            if (pend_next_s) begin
              state_r <= ST_DRAIN;
            end else begin
              state_r    <= ST_CLEAR;
              busy_r     <= 1'b1;
              wr_valid_r <= 1'b1;
              wr_addr_r  <= 7'd0;
              wr_data_r  <= clear_value;
            end
          end
        end
        ST_DRAIN: begin
          if (hs_s) begin
            state_r    <= ST_CLEAR;
            busy_r     <= 1'b1;
            wr_valid_r <= 1'b1;
            wr_addr_r  <= 7'd0;
            wr_data_r  <= clear_val_r;
          end
        end
        ST_CLEAR: begin
          if (hs_s) begin
            if (wr_addr_r == ROW_LAST) begin
              state_r    <= ST_LOAD;
              busy_r     <= 1'b0;
              wr_valid_r <= 1'b0;
            end else begin
              wr_addr_r  <= wr_addr_r + 7'd1;
              wr_valid_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r    <= ST_LOAD;
          busy_r     <= 1'b0;
          wr_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_sched.sv
// Directed bench for fb_write_sched: serial unpacking, overflow, idle timeout,
// fill mode and mid-fill reset, checked against hand-computed words.
module tb_fb_write_sched;

  localparam int ROWS    = 80;
  localparam int TIMEOUT = 24000;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_strobe;
  logic        clear_req;
  logic [31:0] clear_value;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        frame_done;
  logic        overflow;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  // monitor state (written only by the monitor process)
  logic [6:0]  hs_addr_q[$];
  logic [31:0] hs_data_q[$];
  int          cyc_r = 0;
  int          fd_cnt_r = 0;
  int          fd_cyc_r = -1;
  int          last_row_cyc_r = -1;
  int          vrise_cnt_r = 0;
  int          unstable_cnt_r = 0;
  int          busy_hs_cnt_r = 0;
  logic        prev_v_r = 1'b0;
  logic        prev_hs_r = 1'b0;
  logic [6:0]  prev_addr_r = 7'd0;
  logic [31:0] prev_data_r = 32'd0;

  fb_write_sched #(.ROWS(ROWS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_strobe(rx_strobe),
    .clear_req(clear_req), .clear_value(clear_value), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .frame_done(frame_done), .overflow(overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe the write port mid-cycle, away from the active edge
  always @(negedge clk) begin
    cyc_r <= cyc_r + 1;
    if (reset) begin
      if (wr_valid && wr_ready) begin
        hs_addr_q.push_back(wr_addr);
        hs_data_q.push_back(wr_data);
        if (busy) busy_hs_cnt_r <= busy_hs_cnt_r + 1;
        if (wr_addr == 7'(ROWS - 1)) last_row_cyc_r <= cyc_r;
      end
      if (frame_done) begin
        fd_cnt_r <= fd_cnt_r + 1;
        fd_cyc_r <= cyc_r;
      end
      if (wr_valid && !prev_v_r) vrise_cnt_r <= vrise_cnt_r + 1;
      if (prev_v_r && !prev_hs_r &&
          (wr_valid !== 1'b1 || wr_addr !== prev_addr_r || wr_data !== prev_data_r))
        unstable_cnt_r <= unstable_cnt_r + 1;
      prev_v_r <= wr_valid;
    end else begin
      prev_v_r <= 1'b0;
    end
    prev_hs_r   <= wr_valid & wr_ready;
    prev_addr_r <= wr_addr;
    prev_data_r <= wr_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [31:0] pack_word(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0]  bs[4];
    logic [31:0] w;
    bs = '{b0, b1, b2, b3};
    w = 32'd0;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) begin
        w[4 * (3 - j) + i]      = bs[j][2 * i];
        w[16 + 4 * (3 - j) + i] = bs[j][2 * i + 1];
      end
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data   = b;
    rx_strobe = 1'b1;
    tick();
    rx_strobe = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n;
    n = 0;
    while (hs_addr_q.size() < target && n < budget) begin
      tick();
      n++;
    end
    if (hs_addr_q.size() < target) check("wait_hs_timeout", 32'(hs_addr_q.size()), 32'(target));
  endtask

  logic [7:0]  stream[320];
  logic [7:0]  bq[4];
  logic [31:0] w_exp;
  int          base;
  int          fd_base;
  int          vr_base;
  int          un_base;
  int          bh_base;

  initial begin
    reset = 1'b0; rx_data = 8'd0; rx_strobe = 1'b0;
    clear_req = 1'b0; clear_value = 32'd0; wr_ready = 1'b1;
    tick(); tick();
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    tick();

    // single word: 55 AA FF 00
    base = hs_addr_q.size(); vr_base = vrise_cnt_r;
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'hFF); send_byte(8'h00);
    repeat (5) tick();
    check("one_hs_count", 32'(hs_addr_q.size() - base), 32'd1);
    if (hs_addr_q.size() > base) begin
      check("one_addr", 32'(hs_addr_q[base]), 32'd0);
      check("one_data_const", hs_data_q[base], 32'h0FF0F0F0);
      check("one_data_model", hs_data_q[base], pack_word(8'h55, 8'hAA, 8'hFF, 8'h00));
    end
    check("one_vrise", 32'(vrise_cnt_r - vr_base), 32'd1);

    // full frame of 320 bytes
    do_reset();
    base = hs_addr_q.size(); fd_base = fd_cnt_r;
    for (int i = 0; i < 320; i++) stream[i] = 8'(i * 37 + 11);
    for (int i = 0; i < 320; i++) send_byte(stream[i]);
    repeat (5) tick();
    check("frame_hs_count", 32'(hs_addr_q.size() - base), 32'(ROWS));
    for (int r = 0; r < ROWS; r++) begin
      if (hs_addr_q.size() > base + r) begin
        check("frame_addr", 32'(hs_addr_q[base + r]), 32'(r));
        check("frame_data", hs_data_q[base + r],
              pack_word(stream[4*r], stream[4*r+1], stream[4*r+2], stream[4*r+3]));
      end
    end
    check("frame_done_count", 32'(fd_cnt_r - fd_base), 32'd1);
    check("frame_done_timing", 32'(fd_cyc_r), 32'(last_row_cyc_r + 1));
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    wait_hs(base + ROWS + 1, 20);
    if (hs_addr_q.size() > base + ROWS) begin
      check("frame_wrap_addr", 32'(hs_addr_q[base + ROWS]), 32'd0);
      check("frame_wrap_data", hs_data_q[base + ROWS], pack_word(8'h12, 8'h34, 8'h56, 8'h78));
    end

    // overflow with wr_ready held low
    do_reset();
    wr_ready = 1'b0;
    base = hs_addr_q.size(); un_base = unstable_cnt_r;
    send_byte(8'h01); send_byte(8'h23); send_byte(8'h45); send_byte(8'h67);
    send_byte(8'h89); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF);
    tick();
    w_exp = pack_word(8'h01, 8'h23, 8'h45, 8'h67);
    check("ovf_valid_held", 32'(wr_valid), 32'd1);
    check("ovf_addr_held", 32'(wr_addr), 32'd0);
    check("ovf_data_held", wr_data, w_exp);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_no_hs", 32'(hs_addr_q.size() - base), 32'd0);
    wr_ready = 1'b1;
    repeat (4) tick();
    check("ovf_release_hs", 32'(hs_addr_q.size() - base), 32'd1);
    if (hs_addr_q.size() > base) check("ovf_release_data", hs_data_q[base], w_exp);
    check("ovf_stable", 32'(unstable_cnt_r - un_base), 32'd0);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_hs(base + 2, 20);
    if (hs_addr_q.size() > base + 1) check("ovf_offset_adv", 32'(hs_addr_q[base + 1]), 32'd2);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // idle timeout after a partial word
    do_reset();
    base = hs_addr_q.size();
    send_byte(8'hC3); send_byte(8'h3C); send_byte(8'h5A); send_byte(8'hA5); send_byte(8'h99);
    repeat (TIMEOUT) tick();
    send_byte(8'h0F); send_byte(8'hF0); send_byte(8'h66); send_byte(8'h81);
    wait_hs(base + 2, 20);
    if (hs_addr_q.size() > base + 1) begin
      check("tmo_addr", 32'(hs_addr_q[base + 1]), 32'd0);
      check("tmo_data", hs_data_q[base + 1], pack_word(8'h0F, 8'hF0, 8'h66, 8'h81));
    end

    // one cycle short of the timeout keeps the partial word
    do_reset();
    base = hs_addr_q.size();
    send_byte(8'hC3); send_byte(8'h3C); send_byte(8'h5A); send_byte(8'hA5); send_byte(8'h99);
    repeat (TIMEOUT - 1) tick();
    send_byte(8'h0F); send_byte(8'hF0); send_byte(8'h66);
    wait_hs(base + 2, 20);
    if (hs_addr_q.size() > base + 1) begin
      check("near_tmo_addr", 32'(hs_addr_q[base + 1]), 32'd1);
      check("near_tmo_data", hs_data_q[base + 1], pack_word(8'h99, 8'h0F, 8'hF0, 8'h66));
    end

    // clear while a write is pending
    do_reset();
    wr_ready = 1'b0;
    base = hs_addr_q.size(); fd_base = fd_cnt_r; bh_base = busy_hs_cnt_r;
    bq = '{8'h13, 8'h57, 8'h9B, 8'hDF};
    for (int i = 0; i < 4; i++) send_byte(bq[i]);
    w_exp = pack_word(bq[0], bq[1], bq[2], bq[3]);
    clear_value = 32'hDEADBEEF;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    clear_value = 32'h0;
    for (int i = 0; i < 4; i++) send_byte(8'hFF);
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_data_held", wr_data, w_exp);
    wr_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i));
    wait_hs(base + 1 + ROWS, 300);
    repeat (6) tick();
    check("clr_hs_count", 32'(hs_addr_q.size() - base), 32'(ROWS + 1));
    if (hs_addr_q.size() > base) begin
      check("clr_first_addr", 32'(hs_addr_q[base]), 32'd0);
      check("clr_first_data", hs_data_q[base], w_exp);
    end
    for (int r = 0; r < ROWS; r++) begin
      if (hs_addr_q.size() > base + 1 + r) begin
        check("clr_addr", 32'(hs_addr_q[base + 1 + r]), 32'(r));
        check("clr_data", hs_data_q[base + 1 + r], 32'hDEADBEEF);
      end
    end
    check("clr_busy_hs", 32'(busy_hs_cnt_r - bh_base), 32'(ROWS));
    check("clr_frame_done", 32'(fd_cnt_r - fd_base), 32'd1);
    check("clr_busy_after", 32'(busy), 32'd0);
    check("clr_no_overflow", 32'(overflow), 32'd0);
    send_byte(8'h24); send_byte(8'h68); send_byte(8'hAC); send_byte(8'hE0);
    wait_hs(base + ROWS + 2, 20);
    if (hs_addr_q.size() > base + ROWS + 1) begin
      check("clr_after_addr", 32'(hs_addr_q[base + ROWS + 1]), 32'd0);
      check("clr_after_data", hs_data_q[base + ROWS + 1], pack_word(8'h24, 8'h68, 8'hAC, 8'hE0));
    end

    // reset in the middle of a clear
    do_reset();
    base = hs_addr_q.size();
    clear_value = 32'hCAFEF00D;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_hs(base + 40, 200);
    check("mid_addr_40", 32'(wr_addr), 32'd40);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid_rst_valid", 32'(wr_valid), 32'd0);
    check("mid_rst_addr", 32'(wr_addr), 32'd0);
    check("mid_rst_data", wr_data, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_fd", 32'(frame_done), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    base = hs_addr_q.size();
    tick();
    check("mid_rst_valid_next", 32'(wr_valid), 32'd0);
    send_byte(8'h5F); send_byte(8'hF5); send_byte(8'h0A); send_byte(8'hA0);
    wait_hs(base + 1, 20);
    repeat (3) tick();
    check("mid_rst_hs_count", 32'(hs_addr_q.size() - base), 32'd1);
    if (hs_addr_q.size() > base) begin
      check("mid_rst_row0", 32'(hs_addr_q[base]), 32'd0);
      check("mid_rst_data0", hs_data_q[base], pack_word(8'h5F, 8'hF5, 8'h0A, 8'hA0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
